// File: rtl/sb_pkg.sv
// Shared types and helpers for the latency-aware issue scoreboard.
// The writeback entry carries a register address of the default architectural width.
package sb_pkg;
    localparam int SB_DEFAULT_MAX_LAT = 8;
    localparam int SB_REG_ADDR_W      = 5;

    typedef struct packed {
        logic                     valid;
        logic [SB_REG_ADDR_W-1:0] rd;
    } sb_wb_entry_t;

    function automatic int sb_lat_w(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction
endpackage

// File: rtl/sb_wb_shift.sv
// Writeback reservation shift register: entry k retires k cycles from now.
// Inserts land at an arbitrary depth; the query port reports occupancy at a given depth.
module sb_wb_shift
    import sb_pkg::*;
#(
    parameter int MAX_LAT = SB_DEFAULT_MAX_LAT,
    parameter int LAT_W   = sb_lat_w(MAX_LAT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ins_en,
    input  logic [LAT_W-1:0]         ins_idx,
    input  logic [SB_REG_ADDR_W-1:0] ins_rd,
    input  logic [LAT_W-1:0]         qry_idx,
    output logic                     qry_valid,
    output sb_wb_entry_t             head
);
    sb_wb_entry_t pipe [MAX_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LAT; k++) pipe[k] <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT - 1; k++) pipe[k] <= pipe[k+1];
            pipe[MAX_LAT-1] <= '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                if (ins_en && ins_idx == LAT_W'(k)) pipe[k] <= '{valid: 1'b1, rd: ins_rd};
            end
        end
    end

    // A query index of MAX_LAT or above never matches, so it reads as free.
    always_comb begin
        qry_valid = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (qry_idx == LAT_W'(k)) qry_valid = pipe[k].valid;
        end
    end

    assign head = pipe[0];
endmodule

// File: rtl/pipeline_scoreboard.sv
// Issue-point scoreboard: per-register pending counters plus writeback slot reservation.
// Stalls Decode on RAW, WAW and writeback-port conflicts; reports the retiring destination.
module pipeline_scoreboard
    import sb_pkg::*;
#(
    parameter int  NUM_REGS   = 32,
    parameter int  REG_ADDR_W = SB_REG_ADDR_W,
    parameter int  MAX_LAT    = SB_DEFAULT_MAX_LAT,
    parameter bit  BYPASS     = 1'b1,
    parameter bit  X0_ZERO    = 1'b1,
    localparam int LAT_W      = sb_lat_w(MAX_LAT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_writes_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_uses_rs1,
    input  logic                  issue_uses_rs2,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic                  flush,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [31:0]           stall_cnt
);
    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] lat_eff, cnt_rs1, cnt_rs2, cnt_rd;
    logic             rd_tracked, rs1_tracked, rs2_tracked;
    logic             raw, waw, slot_busy, accept;
    sb_wb_entry_t     head;

    function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] r);
        return !X0_ZERO || (r != '0);
    endfunction

    function automatic logic src_busy(input logic [LAT_W-1:0] c);
        return (c > LAT_W'(1)) || (c == LAT_W'(1) && !BYPASS);
    endfunction

    // A zero latency is illegal; treating it as single-cycle keeps the slot index in range.
    assign lat_eff = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (issue_rs1 == REG_ADDR_W'(r)) cnt_rs1 = cnt[r];
            if (issue_rs2 == REG_ADDR_W'(r)) cnt_rs2 = cnt[r];
            if (issue_rd  == REG_ADDR_W'(r)) cnt_rd  = cnt[r];
        end
    end

    assign rd_tracked  = issue_writes_rd && is_tracked(issue_rd);
    assign rs1_tracked = issue_uses_rs1 && is_tracked(issue_rs1);
    assign rs2_tracked = issue_uses_rs2 && is_tracked(issue_rs2);

    assign raw    = (rs1_tracked && src_busy(cnt_rs1)) || (rs2_tracked && src_busy(cnt_rs2));
    assign waw    = rd_tracked && (cnt_rd > lat_eff);
    assign stall  = issue_valid && (raw || waw || (rd_tracked && slot_busy));
    assign accept = issue_valid && !stall && !flush;

    // A fresh reservation overrides the decrement, so same-cycle retire and re-issue keeps the new count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (accept && rd_tracked && issue_rd == REG_ADDR_W'(r)) cnt[r] <= lat_eff;
                else if (cnt[r] != '0) cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (issue_valid && stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end

    sb_wb_shift #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_wb_shift (
        .clk       (clk),
        .rst       (rst),
        .ins_en    (accept && rd_tracked),
        .ins_idx   (lat_eff - LAT_W'(1)),
        .ins_rd    (SB_REG_ADDR_W'(issue_rd)),
        .qry_idx   (lat_eff),
        .qry_valid (slot_busy),
        .head      (head)
    );

    assign wb_valid = head.valid;
    assign wb_rd    = REG_ADDR_W'(head.rd);
endmodule

// File: doc/pipeline_scoreboard.md
# pipeline_scoreboard

- Parametrised, latency-aware scoreboard that generalises the fixed-depth hazard and forwarding logic of the 5-stage core.
- Supports functional units of different latencies (integer ALU, multi-cycle FP) issuing in order but completing at different times.
- Sits at the Decode→Execute issue point. It tracks pending destination registers and reserves writeback slots.
- Raises `stall` on RAW, WAW and writeback-port conflicts, and emits the retiring destination each cycle.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers tracked.
- `REG_ADDR_W`, 5: register address width; must satisfy 2^`REG_ADDR_W` ≥ `NUM_REGS`.
- `MAX_LAT`, 8: maximum issue latency in cycles, ≥ 2.
- `BYPASS`, 1: 1 means a consumer may issue in the producer's writeback cycle.
- `X0_ZERO`, 1: 1 means register 0 is never tracked.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `issue_valid`  in  1  Decode presents an instruction.
- `issue_rd`  in  `REG_ADDR_W`  destination register.
- `issue_writes_rd`  in  1  instruction writes `issue_rd`.
- `issue_rs1`, `issue_rs2`  in  `REG_ADDR_W`  source registers.
- `issue_uses_rs1`, `issue_uses_rs2`  in  1  source operand is used.
- `issue_lat`  in  clog2(`MAX_LAT`+1)  result latency, 1..`MAX_LAT`.
- `flush`  in  1  kills the instruction in Decode; no issue this cycle.
- `stall`  out  1  combinational; Decode must hold.
- `wb_valid`  out  1  registered; a tracked result writes back this cycle.
- `wb_rd`  out  `REG_ADDR_W`  registered; destination retiring this cycle.
- `stall_cnt`  out  32  registered, saturating count of stall cycles.

## Operation
State:
- `cnt[r]`: one per register, width clog2(`MAX_LAT`+1).
- `wb_pipe[0..MAX_LAT-1]`: `{valid, rd}` entries.
- `wb_valid`/`wb_rd` are driven from `wb_pipe[0]`.

A register r is tracked when `issue_writes_rd` is set and (`X0_ZERO`=0 or r≠0). Untracked destinations and sources never cause a hazard and reserve no slot.

Hazards, each evaluated only for tracked registers and only when `issue_valid`:
- RAW: a used source s has `cnt[s]` > 1, or `cnt[s]` == 1 while `BYPASS`=0.
- WAW: `cnt[issue_rd]` > `issue_lat`.
- Structural: `issue_lat` < `MAX_LAT` and `wb_pipe[issue_lat].valid`.

`stall` = `issue_valid` & (RAW | WAW | structural). `flush` does not mask `stall`.

An instruction is accepted when `issue_valid` & ~`stall` & ~`flush`.

Every edge:
- All nonzero `cnt` decrement.
- `wb_pipe[k]` ← `wb_pipe[k+1]`; the top entry is cleared.
- On accept with a tracked rd: `cnt[rd]` ← `issue_lat` (this overrides the decrement) and `wb_pipe[issue_lat-1]` ← `{1, rd}`. The slot is free by construction.

Other rules:
- `issue_lat` = 0 is illegal; the bench asserts it never occurs, and RTL treats it as 1.
- `stall_cnt` increments on `issue_valid` & `stall` & ~`flush` and saturates at 0xFFFF_FFFF.

## Timing
- Reset, asynchronous: all `cnt` = 0, all `wb_pipe` invalid, `wb_valid` = 0, `wb_rd` = 0, `stall_cnt` = 0, `stall` = 0.
- Reset asserted mid-operation discards all in-flight reservations immediately.
- Accept in cycle t with latency L:
  - `wb_valid`=1 and `wb_rd`=rd in cycle t+L.
  - `cnt[rd]` = L in cycle t+1, falling to 1 in cycle t+L and 0 in cycle t+L+1.
- RAW consumer of that rd:
  - `BYPASS`=1: issues no earlier than cycle t+L.
  - `BYPASS`=0: issues no earlier than cycle t+L+1.
- Same-cycle retire and re-issue of the same rd is legal: the new `cnt` wins, and the retiring `wb_valid` pulse still occurs.
- WAW rule guarantees writebacks to one rd happen in issue order, never in the same cycle.
- At most one `wb_valid` per cycle.

## Structure
- Shared package `sb_pkg`:
  - `sb_wb_entry_t` (`{valid, rd}`).
  - Latency-width localparam function.
  - Default `MAX_LAT`.
- One sub-module, `sb_wb_shift`: `MAX_LAT`-deep reservation shift register with an indexed insert port and an occupancy query port.
- Counters, hazard compare and `stall_cnt` stay in the top module.

## Test plan
- Reset check: issue rd=5, L=4 in cycle 0, then hold `issue_valid`=0. Expect `wb_valid`=1 and `wb_rd`=5 in cycle 4 only, and `wb_valid`=0 in cycles 1–3 and 5.
- RAW bypass: rd=7, L=3 at t=0, then rs1=7 presented from t=1. Expect `stall`=1 in cycles 1–2 and accept in cycle 3 with `BYPASS`=1. With `BYPASS`=0, stall persists through cycle 3 and accept occurs in cycle 4.
- Structural: issue rd=1, L=4 at t=0, then rd=2, L=3 at t=1 (same writeback cycle). Expect `stall`=1 at t=1 and accept at t=2, with `wb_rd`=1 at cycle 4 and `wb_rd`=2 at cycle 5.
- WAW plus `flush`:
  - Issue rd=3, L=6 at t=0; then rd=3, L=2 at t=1. Expect stall until `cnt[3]` ≤ 2.
  - Separately, `issue_valid`=`flush`=1 while not stalled: nothing is reserved and `stall_cnt` is unchanged.
- `x0` plus reset mid-flight:
  - With rd=0 writes, expect no stall and no `wb_valid`.
  - Issue rd=9, L=8, assert `rst` at t=3: `wb_valid` never rises for rd=9 and `stall_cnt` reads 0.
